// File: rtl/clk_div_pkg.sv
// Shared types for the programmable clock divider: controller states,
// config payload and the config validity rule.
package clk_div_pkg;

  // Widest period/high field the controller supports; narrower CW is zero-extended.
  localparam int unsigned MAX_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_e;

  typedef struct packed {
    logic [MAX_CW-1:0] period;
    logic [MAX_CW-1:0] high;
  } cfg_t;

  // A period needs at least two cycles and a non-empty, non-full high phase.
  function automatic logic cfg_ok(input cfg_t c);
    return (c.period >= MAX_CW'(2)) && (c.high != '0) && (c.high < c.period);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: active period/high registers, cycle counter with wrap
// detect, and the registered clk_out/tick compare.
module clk_div_core #(
  parameter int unsigned CW         = 8,
  parameter int unsigned DEF_PERIOD = 5,
  parameter int unsigned DEF_HIGH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] ld_period,
  input  logic [CW-1:0] ld_high,
  input  logic          run,
  output logic [CW-1:0] act_period,
  output logic          wrap_c,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] count_q, count_d;
  logic          run_q;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;

  // Outputs are computed from the next count so they line up with count_q.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    if (load) begin
      period_d = ld_period;
      high_d   = ld_high;
    end
    wrap_c  = run_q && (count_q == (period_q - CW'(1)));
    count_d = '0;
    if (run && run_q && !wrap_c) begin
      count_d = count_q + CW'(1);
    end
    clk_out_d = run && (count_d < high_d);
    tick_d    = run && (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q  <= CW'(DEF_PERIOD);
      high_q    <= CW'(DEF_HIGH);
      count_q   <= '0;
      run_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      period_q  <= period_d;
      high_q    <= high_d;
      count_q   <= count_d;
      run_q     <= run;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign act_period = period_q;
  assign clk_out    = clk_out_q;
  assign tick       = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: config handshake, shadow register and run/stop
// FSM around clk_div_core. New settings only take effect at a period boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CW         = 8,
  parameter int unsigned DEF_PERIOD = 5,
  parameter int unsigned DEF_HIGH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          tick,
  output logic          busy,
  output logic [CW-1:0] act_period
);

  state_e state_q, state_d;
  cfg_t   shadow_q, shadow_d;
  cfg_t   offer;
  cfg_t   ld_cfg;
  logic   cfg_ready_q, cfg_ready_d;
  logic   cfg_err_q, cfg_err_d;
  logic   busy_q, busy_d;
  logic   xfer;
  logic   offer_ok;
  logic   load;
  logic   run;
  logic   wrap_c;

  // Next state, handshake and load strobe.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    ld_cfg       = shadow_q;
    load         = 1'b0;
    cfg_err_d    = 1'b0;
    offer.period = MAX_CW'(cfg_period);
    offer.high   = MAX_CW'(cfg_high);
    offer_ok     = cfg_ok(offer);
    xfer         = cfg_valid && cfg_ready_q;
    if (xfer && !offer_ok) begin
      cfg_err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (xfer && offer_ok) begin
          load   = 1'b1;
          ld_cfg = offer;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A config offered alongside en=0 wins; the stop is taken at its apply wrap.
        if (xfer && offer_ok) begin
          shadow_d = offer;
          state_d  = PEND;
        end else if (!en) begin
          state_d = wrap_c ? IDLE : STOP;
        end
      end
      PEND: begin
        if (wrap_c) begin
          load    = 1'b1;
          ld_cfg  = shadow_q;
          state_d = en ? RUN : IDLE;
        end
      end
      STOP: begin
        if (en) begin
          state_d = RUN;
        end else if (wrap_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    run         = (state_d != IDLE);
    busy_d      = run;
    cfg_ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  clk_div_core #(
    .CW        (CW),
    .DEF_PERIOD(DEF_PERIOD),
    .DEF_HIGH  (DEF_HIGH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .ld_period (CW'(ld_cfg.period)),
    .ld_high   (CW'(ld_cfg.high)),
    .run       (run),
    .act_period(act_period),
    .wrap_c    (wrap_c),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: hand-computed clk_out/tick/handshake
// sequences for defaults, reconfiguration, rejection, stop/restart and reset.
module tb_clk_div_ctrl;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_valid;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_high;
  logic          cfg_ready;
  logic          cfg_err;
  logic          clk_out;
  logic          tick;
  logic          busy;
  logic [CW-1:0] act_period;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] pat10;
  logic [7:0] pat8;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CW        (CW),
    .DEF_PERIOD(5),
    .DEF_HIGH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .act_period(act_period)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    en         = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic offer(input int n, input int h);
    cfg_valid  = 1'b1;
    cfg_period = CW'(n);
    cfg_high   = CW'(h);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk"},   32'(clk_out),    32'(0));
    chk({tag, "_tick"},  32'(tick),       32'(0));
    chk({tag, "_err"},   32'(cfg_err),    32'(0));
    chk({tag, "_ready"}, 32'(cfg_ready),  32'(1));
    chk({tag, "_busy"},  32'(busy),       32'(0));
    chk({tag, "_per"},   32'(act_period), 32'(5));
  endtask

  initial begin
    // Defaults after reset: /5, 2 high.
    do_reset();
    chk_idle("rst");
    en    = 1'b1;
    pat10 = 10'b1100011000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("def_clk",  32'(clk_out), 32'(pat10[9-i]));
      chk("def_tick", 32'(tick),    32'(i % 5 == 0));
    end
    chk("def_per",  32'(act_period), 32'(5));
    chk("def_busy", 32'(busy),       32'(1));

    // Config in IDLE goes straight to the active registers.
    do_reset();
    offer(4, 2);
    cyc();
    cfg_valid = 1'b0;
    chk("idle_per",   32'(act_period), 32'(4));
    chk("idle_ready", 32'(cfg_ready),  32'(1));
    chk("idle_busy",  32'(busy),       32'(0));
    chk("idle_clk",   32'(clk_out),    32'(0));
    en   = 1'b1;
    pat8 = 8'b11001100;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("n4_clk",   32'(clk_out),   32'(pat8[7-i]));
      chk("n4_ready", 32'(cfg_ready), 32'(1));
    end

    // Reconfigure to /10 with 3 high at count 2 of a /5 period.
    do_reset();
    en = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rc_c2_clk", 32'(clk_out), 32'(0));
    offer(10, 3);
    cyc();
    cfg_valid = 1'b0;
    chk("rc_c3_ready", 32'(cfg_ready), 32'(0));
    chk("rc_c3_busy",  32'(busy),      32'(1));
    cyc();
    chk("rc_c4_ready", 32'(cfg_ready),  32'(0));
    chk("rc_c4_per",   32'(act_period), 32'(5));
    chk("rc_c4_tick",  32'(tick),       32'(0));
    cyc();
    chk("rc_new_tick",  32'(tick),       32'(1));
    chk("rc_new_clk",   32'(clk_out),    32'(1));
    chk("rc_new_per",   32'(act_period), 32'(10));
    chk("rc_new_ready", 32'(cfg_ready),  32'(1));
    for (int i = 1; i < 10; i++) begin
      cyc();
      chk("n10_clk",  32'(clk_out), 32'(i < 3));
      chk("n10_tick", 32'(tick),    32'(0));
    end
    cyc();
    chk("n10_wrap_tick", 32'(tick),    32'(1));
    chk("n10_wrap_clk",  32'(clk_out), 32'(1));

    // Invalid configs are consumed with a one-cycle error pulse.
    offer(4, 4);
    cyc();
    cfg_valid = 1'b0;
    chk("bad1_err", 32'(cfg_err),    32'(1));
    chk("bad1_clk", 32'(clk_out),    32'(1));
    chk("bad1_per", 32'(act_period), 32'(10));
    cyc();
    chk("bad1_err_end", 32'(cfg_err), 32'(0));
    offer(1, 0);
    cyc();
    cfg_valid = 1'b0;
    chk("bad2_err",   32'(cfg_err),   32'(1));
    chk("bad2_clk",   32'(clk_out),   32'(0));
    chk("bad2_ready", 32'(cfg_ready), 32'(1));
    cyc();
    chk("bad2_err_end", 32'(cfg_err),    32'(0));
    chk("bad2_per",     32'(act_period), 32'(10));
    chk("bad2_busy",    32'(busy),       32'(1));

    // Drop en at count 1: period completes, then idle; restart ticks next cycle.
    do_reset();
    en = 1'b1;
    cyc();
    chk("st_c0_clk", 32'(clk_out), 32'(1));
    cyc();
    chk("st_c1_clk", 32'(clk_out), 32'(1));
    en = 1'b0;
    cyc();
    chk("st_c2_clk",  32'(clk_out), 32'(0));
    chk("st_c2_busy", 32'(busy),    32'(1));
    cyc();
    cyc();
    chk("st_c4_busy", 32'(busy), 32'(1));
    chk("st_c4_tick", 32'(tick), 32'(0));
    cyc();
    chk("st_end_busy", 32'(busy),    32'(0));
    chk("st_end_clk",  32'(clk_out), 32'(0));
    chk("st_end_tick", 32'(tick),    32'(0));
    cyc();
    chk("st_hold_clk", 32'(clk_out), 32'(0));
    en = 1'b1;
    cyc();
    chk("re_tick", 32'(tick),    32'(1));
    chk("re_clk",  32'(clk_out), 32'(1));
    chk("re_busy", 32'(busy),    32'(1));
    // Brief en drop inside a period resumes without a discontinuity.
    cyc();
    en = 1'b0;
    cyc();
    chk("bl_c2_ready", 32'(cfg_ready), 32'(0));
    chk("bl_c2_busy",  32'(busy),      32'(1));
    en = 1'b1;
    cyc();
    chk("bl_c3_ready", 32'(cfg_ready), 32'(1));
    chk("bl_c3_clk",   32'(clk_out),   32'(0));
    cyc();
    chk("bl_c4_tick", 32'(tick), 32'(0));
    cyc();
    chk("bl_c0_tick", 32'(tick),    32'(1));
    chk("bl_c0_clk",  32'(clk_out), 32'(1));

    // Reset while a config is pending drops it.
    do_reset();
    en = 1'b1;
    cyc();
    offer(8, 3);
    cyc();
    cfg_valid = 1'b0;
    chk("pr_pend_ready", 32'(cfg_ready), 32'(0));
    rst = 1'b1;
    en  = 1'b0;
    cyc();
    chk_idle("pr_rst");
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("pr_tick", 32'(tick), 32'(i % 5 == 0));
    end
    chk("pr_per", 32'(act_period), 32'(5));

    // Config accepted on the wrap cycle applies one full period later.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
    end
    offer(6, 1);
    cyc();
    cfg_valid = 1'b0;
    chk("wr_tick",  32'(tick),       32'(1));
    chk("wr_per",   32'(act_period), 32'(5));
    chk("wr_ready", 32'(cfg_ready),  32'(0));
    for (int i = 0; i < 4; i++) begin
      cyc();
    end
    chk("wr_c4_per", 32'(act_period), 32'(5));
    cyc();
    chk("wr_new_per",  32'(act_period), 32'(6));
    chk("wr_new_tick", 32'(tick),       32'(1));
    chk("wr_new_ready", 32'(cfg_ready), 32'(1));
    cyc();
    chk("wr_c1_clk", 32'(clk_out), 32'(0));

    // en low together with an offer: apply at the wrap, then go idle.
    offer(3, 1);
    en = 1'b0;
    cyc();
    cfg_valid = 1'b0;
    chk("ec_ready", 32'(cfg_ready), 32'(0));
    chk("ec_busy",  32'(busy),      32'(1));
    cyc();
    cyc();
    cyc();
    chk("ec_c5_busy", 32'(busy),       32'(1));
    chk("ec_c5_per",  32'(act_period), 32'(6));
    cyc();
    chk("ec_end_busy", 32'(busy),       32'(0));
    chk("ec_end_per",  32'(act_period), 32'(3));
    chk("ec_end_clk",  32'(clk_out),    32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
